// File: rtl/stream_sink_checker.sv
// Valid/ready stream sink: accepts words under LFSR-driven backpressure and checks them against an expected-data RAM.
// Optional: define STREAM_SINK_STOP_ON_ERR_EN to end the run on the first mismatching word.
module stream_sink_checker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [AW:0]       i_len,
  input  logic [31:0]       i_seed,
  input  logic [3:0]        i_throttle,
  input  logic              i_exp_we,
  input  logic [AW-1:0]     i_exp_addr,
  input  logic [DATA_W-1:0] i_exp_data,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [AW:0]       o_rx_cnt,
  output logic [15:0]       o_err_cnt,
  output logic [AW-1:0]     o_first_err_idx,
  output logic [DATA_W-1:0] o_first_err_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic [AW:0]       len_q;
  logic [AW:0]       rx_cnt_q;
  logic [AW:0]       rx_cnt_d;
  logic [15:0]       err_cnt_q;
  logic [15:0]       err_cnt_d;
  logic [AW-1:0]     first_idx_q;
  logic [DATA_W-1:0] first_data_q;

  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic [DATA_W-1:0] exp_word;

  logic len_ok;
  logic start_ok;
  logic accept;
  logic mismatch;
  logic last_word;
  logic stop_now;
  logic unused_seed_hi;

  assign unused_seed_hi = ^i_seed[31:16];

  assign len_ok   = (i_len != '0) && (i_len <= (AW+1)'(DEPTH));
  assign start_ok = i_start && (state_q != S_RUN) && len_ok;

  // Ready depends only on registered state, so the DUT may legally wait on it.
  assign o_ready  = (state_q == S_RUN) && (lfsr_q[3:0] >= i_throttle);
  assign accept   = i_valid && o_ready;

  assign exp_word = exp_mem[rx_cnt_q[AW-1:0]];
  assign mismatch = accept && (i_data != exp_word);

  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign rx_cnt_d  = rx_cnt_q + 1'b1;
  assign err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
  assign last_word = (rx_cnt_d == len_q);

`ifdef STREAM_SINK_STOP_ON_ERR_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // NOTE: the expected RAM has no reset on purpose; its contents must survive
  // reset and it maps onto plain block RAM only when left unreset.
  always_ff @(posedge i_clk) begin
    if (i_exp_we && (state_q != S_RUN)) begin
      exp_mem[i_exp_addr] <= i_exp_data;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= 16'h0001;
      len_q        <= '0;
      rx_cnt_q     <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          lfsr_q <= lfsr_d;
          if (accept) begin
            rx_cnt_q <= rx_cnt_d;
            if (mismatch) begin
              err_cnt_q <= err_cnt_d;
              if (err_cnt_q == '0) begin
                first_idx_q  <= rx_cnt_q[AW-1:0];
                first_data_q <= i_data;
              end
            end
            if (last_word || stop_now) begin
              state_q <= S_DONE;
            end
          end
        end
        default: begin
          if (start_ok) begin
            state_q      <= S_RUN;
            lfsr_q       <= (i_seed[15:0] == 16'h0000) ? 16'h0001 : i_seed[15:0];
            len_q        <= i_len;
            rx_cnt_q     <= '0;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_data_q <= '0;
          end
        end
      endcase
    end
  end

  assign o_busy           = (state_q == S_RUN);
  assign o_done           = (state_q == S_DONE);
  assign o_pass           = o_done && (err_cnt_q == '0);
  assign o_rx_cnt         = rx_cnt_q;
  assign o_err_cnt        = err_cnt_q;
  assign o_first_err_idx  = first_idx_q;
  assign o_first_err_data = first_data_q;

endmodule

// File: tb/tb_stream_sink_checker.sv
// Randomized bench for stream_sink_checker: a word-list model predicts the ready pattern and the run verdict.
module tb_stream_sink_checker;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int AW     = $clog2(DEPTH);
`ifdef STREAM_SINK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic [AW:0]       i_len;
  logic [31:0]       i_seed;
  logic [3:0]        i_throttle;
  logic              i_exp_we;
  logic [AW-1:0]     i_exp_addr;
  logic [DATA_W-1:0] i_exp_data;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic [AW:0]       o_rx_cnt;
  logic [15:0]       o_err_cnt;
  logic [AW-1:0]     o_first_err_idx;
  logic [DATA_W-1:0] o_first_err_data;

  stream_sink_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (i_start),
    .i_len            (i_len),
    .i_seed           (i_seed),
    .i_throttle       (i_throttle),
    .i_exp_we         (i_exp_we),
    .i_exp_addr       (i_exp_addr),
    .i_exp_data       (i_exp_data),
    .i_data           (i_data),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pass           (o_pass),
    .o_rx_cnt         (o_rx_cnt),
    .o_err_cnt        (o_err_cnt),
    .o_first_err_idx  (o_first_err_idx),
    .o_first_err_data (o_first_err_data)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DATA_W-1:0] ram_model [DEPTH];
  logic [DATA_W-1:0] src [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // All tasks begin and end at a falling edge.
  task automatic ram_write(input int addr, input logic [DATA_W-1:0] data);
    i_exp_we   = 1'b1;
    i_exp_addr = AW'(addr);
    i_exp_data = data;
    @(negedge clk);
    i_exp_we   = 1'b0;
    ram_model[addr] = data;
  endtask

  task automatic start(input int len, input logic [31:0] seed, input logic [3:0] thr);
    i_len      = (AW+1)'(len);
    i_seed     = seed;
    i_throttle = thr;
    i_start    = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"}, o_ready, 0);
    check({tag, " busy"}, o_busy, 0);
    check({tag, " rx_cnt"}, o_rx_cnt, 0);
    check({tag, " err_cnt"}, o_err_cnt, 0);
  endtask

  task automatic run(input int len, input logic [31:0] seed, input logic [3:0] thr,
                     input int vpct, input bit poke, input string tag);
    logic [15:0] l;
    int idx, cyc, budget, exp_n, nerr, first;
    bit ready_exp;
    nerr  = 0;
    first = -1;
    exp_n = len;
    for (int i = 0; i < exp_n; i++) begin
      if (src[i] !== ram_model[i]) begin
        nerr++;
        if (first < 0) first = i;
        if (STOP_ON_ERR) exp_n = i + 1;
      end
    end

    start(len, seed, thr);
    l      = (seed[15:0] == 16'h0000) ? 16'h0001 : seed[15:0];
    idx    = 0;
    cyc    = 0;
    budget = len * 60 + 100;
    while (idx < exp_n && cyc < budget) begin
      i_valid  = ($urandom_range(99) < vpct);
      i_data   = i_valid ? src[idx] : $urandom;
      i_exp_we = poke && (cyc == 1);
      if (i_exp_we) begin
        i_exp_addr = AW'(2);
        i_exp_data = ~ram_model[2];
      end
      ready_exp = (l[3:0] >= thr);
      #1;
      check({tag, " ready"}, o_ready, ready_exp);
      check({tag, " busy"}, o_busy, 1);
      @(posedge clk);
      if (i_valid && ready_exp) idx++;
      l = lfsr_next(l);
      cyc++;
      @(negedge clk);
    end
    i_exp_we = 1'b0;
    check({tag, " timeout"}, cyc >= budget, 0);

    #1;
    check({tag, " done"}, o_done, 1);
    check({tag, " busy_end"}, o_busy, 0);
    check({tag, " rx_cnt"}, o_rx_cnt, exp_n);
    check({tag, " err_cnt"}, o_err_cnt, nerr);
    check({tag, " pass"}, o_pass, nerr == 0);
    check({tag, " first_idx"}, o_first_err_idx, (first < 0) ? 0 : first);
    check({tag, " first_data"}, o_first_err_data, (first < 0) ? 0 : src[first]);

    // Source keeps offering words after the run: nothing more may be taken.
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = $urandom;
      #1;
      check({tag, " ready_after"}, o_ready, 0);
      @(negedge clk);
    end
    check({tag, " rx_after"}, o_rx_cnt, exp_n);
    i_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_len      = '0;
    i_seed     = '0;
    i_throttle = '0;
    i_exp_we   = 1'b0;
    i_exp_addr = '0;
    i_exp_data = '0;
    i_data     = '0;
    i_valid    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_model[i] = 'x;
      src[i]       = '0;
    end

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset done", o_done, 0);
    check("reset pass", o_pass, 0);
    check("reset first_idx", o_first_err_idx, 0);
    check("reset first_data", o_first_err_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal lengths are ignored.
    start(0, 32'h1, 4'd0);
    #1 check_idle_outputs("len0");
    check("len0 done", o_done, 0);
    @(negedge clk);
    start(DEPTH + 1, 32'h1, 4'd0);
    #1 check_idle_outputs("len_over");
    @(negedge clk);

    // Basic 8-word stream, then the same with words 3 and 6 corrupted.
    for (int i = 0; i < 8; i++) begin
      ram_write(i, DATA_W'(32'h10 + i));
      src[i] = DATA_W'(32'h10 + i);
    end
    run(8, 32'h1, 4'd0, 100, 1'b0, "basic");
    src[3] = 32'hFF;
    src[6] = 32'hFF;
    run(8, 32'h1, 4'd0, 100, 1'b0, "corrupt");

    // LFSR-shaped backpressure with the reference seed and with seed 0.
    for (int i = 0; i < 64; i++) begin
      ram_write(i, $urandom);
      src[i] = ram_model[i];
    end
    run(64, 32'h0000ACE1, 4'd8, 100, 1'b0, "ace1");
    run(32, 32'hFFFF0000, 4'd6, 100, 1'b0, "seed0");

    // Reset in the middle of a 16-word run.
    start(16, 32'h1, 4'd0);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_data  = src[k];
      @(negedge clk);
    end
    i_data = src[5];
    #1;
    check("midrst rx_before", o_rx_cnt, 5);
    check("midrst ready_before", o_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n   = 1'b1;
    i_valid = 1'b0;
    #1 check("midrst done", o_done, 0);
    @(negedge clk);
    run(16, 32'h1, 4'd0, 100, 1'b0, "post_rst");

    // RAM write attempted during RUN must be dropped.
    run(16, $urandom, 4'd3, 80, 1'b1, "poke");

    // Random runs with random contents, backpressure, valid gaps and corruption.
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(64, 1);
      for (int i = 0; i < len; i++) begin
        ram_write(i, $urandom);
        src[i] = ram_model[i];
        if ((r % 3 != 0) && ($urandom_range(9) == 0)) src[i] ^= DATA_W'(1) << $urandom_range(DATA_W - 1);
      end
      run(len, $urandom, 4'($urandom_range(10)), $urandom_range(100, 40), 1'b0, "rand");
    end

    // Full-depth transfer.
    for (int i = 0; i < DEPTH; i++) begin
      ram_write(i, $urandom);
      src[i] = ram_model[i];
    end
    run(DEPTH, $urandom, 4'd0, 100, 1'b0, "full");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
